// File: rtl/iob_pkg.sv
// iob_pkg: shared definitions for the KA10 I/O bus initiator.
//   - IOT opcode encodings carried on cmd_op
//   - sequencer state encoding
//   - device codes of the standard peripherals
//   - helpers: opcode legality and PI priority encoding
package iob_pkg;

    typedef enum logic [2:0] {
        IOB_CONO  = 3'd0,
        IOB_CONI  = 3'd1,
        IOB_DATAO = 3'd2,
        IOB_DATAI = 3'd3,
        IOB_IORST = 3'd4
    } iob_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CLR,
        ST_GAP,
        ST_SET,
        ST_HOLD,
        ST_RD,
        ST_RST,
        ST_DONE
    } iob_state_e;

    // 7-bit device codes (octal device number with the two low bits dropped).
    localparam logic [6:0] DEV_TTY = 7'b0010100;
    localparam logic [6:0] DEV_PTR = 7'b0010001;
    localparam logic [6:0] DEV_PTP = 7'b0010000;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= IOB_IORST;
    endfunction

    // Level 1 is the highest priority; 0 means no request.
    function automatic logic [2:0] pi_highest(input logic [1:7] req);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (req[i]) lvl = 3'(i);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/iob_pulse_timer.sv
// iob_pulse_timer: loadable down-counter used to time every sequencer state.
//   clk_i       clock
//   rst_n_i     synchronous active-low reset
//   load_i      load load_val_i (state entry); counts down afterwards
//   load_val_i  state length in cycles (>= 1)
//   done_o      high on the last cycle of the loaded interval
// The counter holds load_val_i-1 and saturates at zero, so a length of 1
// gives done_o in the very first cycle without wrapping.
module iob_pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/iob_master.sv
// iob_master: processor-side initiator of the KA10 I/O bus.
//   cmd_*      one IOT command at a time (CONO/CONI/DATAO/DATAI/IORST)
//   rsp_*      one-cycle completion pulse, error flag, held read data
//   iobus_*    device select, data, timed clear/set/read/reset strobes,
//              wired-OR read data and PI request lines
//   pi_req     PI requests to the CPU
// Optional macro IOB_PISYNC_EN: PI requests pass through a 2-flop
// synchronizer and an extra output pi_lvl reports the highest active level.
module iob_master
    import iob_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int CLR_CYC   = 2,
    parameter int GAP_CYC   = 1,
    parameter int SET_CYC   = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RD_CYC    = 3,
    parameter int RST_CYC   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:9]  cmd_dev,
    input  logic [0:35] cmd_data,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [0:35] rsp_data,
    output logic        iobus_iob_poweron,
    output logic        iobus_iob_reset,
    output logic        iobus_datao_clear,
    output logic        iobus_datao_set,
    output logic        iobus_cono_clear,
    output logic        iobus_cono_set,
    output logic        iobus_iob_fm_datai,
    output logic        iobus_iob_fm_status,
    output logic [3:9]  iobus_ios,
    output logic [0:35] iobus_iob_out,
    input  logic [0:35] iobus_iob_in,
    input  logic [1:7]  iobus_pi_req,
`ifdef IOB_PISYNC_EN
    output logic [2:0]  pi_lvl,
`endif
    output logic [1:7]  pi_req
);

    localparam int MAX_CYC = (SETUP_CYC > CLR_CYC ? SETUP_CYC : CLR_CYC) > 0 ? 0 : 0;
    localparam int M1 = SETUP_CYC > CLR_CYC ? SETUP_CYC : CLR_CYC;
    localparam int M2 = GAP_CYC > SET_CYC ? GAP_CYC : SET_CYC;
    localparam int M3 = HOLD_CYC > RD_CYC ? HOLD_CYC : RD_CYC;
    localparam int M4 = M1 > M2 ? M1 : M2;
    localparam int M5 = M3 > RST_CYC ? M3 : RST_CYC;
    localparam int CW = $clog2((M4 > M5 ? M4 : M5) + MAX_CYC + 1);

    iob_state_e    state_q, state_d;
    logic [2:0]    op_q;
    logic          err_q;
    logic [3:9]    dev_q;
    logic [0:35]   data_q;
    logic [0:35]   rsp_data_q;
    logic          poweron_q;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;
    logic          accept;
    logic          wr_op;
    logic          drive_bus;

    assign accept = cmd_valid && cmd_ready;
    assign wr_op  = (op_q == IOB_CONO) || (op_q == IOB_DATAO);

    iob_pulse_timer #(.W(CW)) u_timer (
        .clk_i      (clk),
        .rst_n_i    (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // NOTE: every control register, including the command latches, is reset
    // so that the bus outputs derived from them are defined out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            err_q      <= 1'b0;
            dev_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            poweron_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            poweron_q <= 1'b1;
            if (accept) begin
                op_q   <= cmd_op;
                err_q  <= !op_is_legal(cmd_op);
                dev_q  <= cmd_dev;
                data_q <= cmd_data;
            end
            if (state_q == ST_RD && tmr_done) begin
                rsp_data_q <= iobus_iob_in;
            end
        end
    end

    // Every timed state is entered by loading the timer with its length and
    // left on the cycle the timer reports done.
    // NOTE: all outputs of this block get a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!op_is_legal(cmd_op)) begin
                        state_d = ST_DONE;
                    end else if (cmd_op == IOB_IORST) begin
                        state_d  = ST_RST;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(RST_CYC);
                    end else begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(SETUP_CYC);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (wr_op) begin
                        state_d = ST_CLR;
                        tmr_val = CW'(CLR_CYC);
                    end else begin
                        state_d = ST_RD;
                        tmr_val = CW'(RD_CYC);
                    end
                end
            end
            ST_CLR: begin
                if (tmr_done) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(GAP_CYC);
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    state_d  = ST_SET;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SET_CYC);
                end
            end
            ST_SET, ST_RD: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_CYC);
                end
            end
            ST_HOLD, ST_RST: begin
                if (tmr_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign drive_bus = (state_q == ST_SETUP) || (state_q == ST_CLR) ||
                       (state_q == ST_GAP)   || (state_q == ST_SET) ||
                       (state_q == ST_HOLD)  || (state_q == ST_RD);

    assign cmd_ready           = (state_q == ST_IDLE);
    assign rsp_valid           = (state_q == ST_DONE);
    assign rsp_err             = (state_q == ST_DONE) && err_q;
    assign rsp_data            = rsp_data_q;
    assign iobus_iob_poweron   = poweron_q;
    assign iobus_iob_reset     = (state_q == ST_RST);
    assign iobus_cono_clear    = (state_q == ST_CLR) && (op_q == IOB_CONO);
    assign iobus_datao_clear   = (state_q == ST_CLR) && (op_q == IOB_DATAO);
    assign iobus_cono_set      = (state_q == ST_SET) && (op_q == IOB_CONO);
    assign iobus_datao_set     = (state_q == ST_SET) && (op_q == IOB_DATAO);
    assign iobus_iob_fm_status = (state_q == ST_RD)  && (op_q == IOB_CONI);
    assign iobus_iob_fm_datai  = (state_q == ST_RD)  && (op_q == IOB_DATAI);
    assign iobus_ios           = drive_bus ? dev_q : '0;
    assign iobus_iob_out       = (drive_bus && wr_op) ? data_q : '0;

`ifdef IOB_PISYNC_EN
    logic [1:7] pi_s1_q, pi_s2_q;
    logic [2:0] pi_lvl_q;

    // The level is encoded from the first stage so it lines up with pi_req.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pi_s1_q  <= '0;
            pi_s2_q  <= '0;
            pi_lvl_q <= 3'd0;
        end else begin
            pi_s1_q  <= iobus_pi_req;
            pi_s2_q  <= pi_s1_q;
            pi_lvl_q <= pi_highest(pi_s1_q);
        end
    end

    assign pi_req = pi_s2_q;
    assign pi_lvl = pi_lvl_q;
`else
    assign pi_req = iobus_pi_req;
`endif

endmodule

// File: tb/tb_iob_master.sv
// tb_iob_master: directed, table-driven bench for iob_master with a small
// TTY device model on the bus (PI assignment flags and a character buffer).
module tb_iob_master;

    localparam logic [6:0] TTY = 7'b0010100;
    localparam logic [6:0] PTP = 7'b0010000;

    // Strobe vector bit positions.
    localparam logic [6:0] S_RST = 7'b1000000;
    localparam logic [6:0] S_DC  = 7'b0100000;
    localparam logic [6:0] S_DS  = 7'b0010000;
    localparam logic [6:0] S_CC  = 7'b0001000;
    localparam logic [6:0] S_CS  = 7'b0000100;
    localparam logic [6:0] S_FD  = 7'b0000010;
    localparam logic [6:0] S_FS  = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:9]  cmd_dev;
    logic [0:35] cmd_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [0:35] rsp_data;
    logic        iob_poweron;
    logic        iob_reset;
    logic        datao_clear, datao_set, cono_clear, cono_set;
    logic        fm_datai, fm_status;
    logic [3:9]  ios;
    logic [0:35] iob_out;
    logic [0:35] iob_in;
    logic [1:7]  bus_pi_req;
    logic [1:7]  pi_req;
`ifdef IOB_PISYNC_EN
    logic [2:0]  pi_lvl;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] tty_pia;
    logic [6:0] strb;

    always #5 clk = ~clk;

    iob_master dut (
        .clk                 (clk),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_op              (cmd_op),
        .cmd_dev             (cmd_dev),
        .cmd_data            (cmd_data),
        .rsp_valid           (rsp_valid),
        .rsp_err             (rsp_err),
        .rsp_data            (rsp_data),
        .iobus_iob_poweron   (iob_poweron),
        .iobus_iob_reset     (iob_reset),
        .iobus_datao_clear   (datao_clear),
        .iobus_datao_set     (datao_set),
        .iobus_cono_clear    (cono_clear),
        .iobus_cono_set      (cono_set),
        .iobus_iob_fm_datai  (fm_datai),
        .iobus_iob_fm_status (fm_status),
        .iobus_ios           (ios),
        .iobus_iob_out       (iob_out),
        .iobus_iob_in        (iob_in),
        .iobus_pi_req        (bus_pi_req),
`ifdef IOB_PISYNC_EN
        .pi_lvl              (pi_lvl),
`endif
        .pi_req              (pi_req)
    );

    assign strb = {iob_reset, datao_clear, datao_set, cono_clear, cono_set, fm_datai, fm_status};

    // TTY model: CONO clear/set load the PI assignment, CONI returns it,
    // DATAI returns a fixed character, IORST clears the flags.
    always @(posedge clk) begin
        if (iob_reset)                      tty_pia <= 3'd0;
        else if (ios == TTY && cono_clear)  tty_pia <= 3'd0;
        else if (ios == TTY && cono_set)    tty_pia <= tty_pia | iob_out[33:35];
    end

    assign iob_in = (ios == TTY && fm_datai)  ? 36'o101 :
                    (ios == TTY && fm_status) ? {33'b0, tty_pia} : 36'b0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [6:0]  dev;
        logic [35:0] data;
        logic [6:0]  m1;
        int          l1, h1;
        logic [6:0]  m2;
        int          l2, h2;
        int          ios_hi;
        int          done_c;
        logic        err;
        logic [35:0] rdata;
        logic [2:0]  pia;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] op, input logic [6:0] dev,
                                input logic [35:0] data, input logic [6:0] m1, input int l1,
                                input int h1, input logic [6:0] m2, input int l2, input int h2,
                                input int ios_hi, input int done_c, input logic err,
                                input logic [35:0] rdata, input logic [2:0] pia);
        vec_t v;
        v.name = n; v.op = op; v.dev = dev; v.data = data;
        v.m1 = m1; v.l1 = l1; v.h1 = h1; v.m2 = m2; v.l2 = l2; v.h2 = h2;
        v.ios_hi = ios_hi; v.done_c = done_c; v.err = err; v.rdata = rdata; v.pia = pia;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [6:0]  exp_strb;
        logic [6:0]  exp_ios;
        logic [35:0] exp_out;
        logic        wr;
        wr = (v.op == 3'd0) || (v.op == 3'd2);
        @(posedge clk); #1;
        check({v.name, " ready c0"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_dev   = v.dev;
        cmd_data  = v.data;
        for (int c = 1; c <= v.done_c + 1; c++) begin
            @(posedge clk); #1;
            exp_strb = ((c >= v.l1 && c <= v.h1) ? v.m1 : 7'd0) |
                       ((c >= v.l2 && c <= v.h2) ? v.m2 : 7'd0);
            exp_ios  = (c <= v.ios_hi) ? v.dev : 7'd0;
            exp_out  = (wr && c <= v.ios_hi) ? v.data : 36'd0;
            check($sformatf("%s strobes c%0d", v.name, c), 64'(strb), 64'(exp_strb));
            check($sformatf("%s ios c%0d", v.name, c), 64'(ios), 64'(exp_ios));
            check($sformatf("%s iob_out c%0d", v.name, c), 64'(iob_out), 64'(exp_out));
            check($sformatf("%s rsp/ready c%0d", v.name, c),
                  64'({rsp_valid, rsp_err, cmd_ready}),
                  64'({c == v.done_c, (c == v.done_c) && v.err, c > v.done_c}));
            if (c == 1) begin
                // Inputs change after acceptance: the DUT must use its latched copy.
                cmd_valid = 1'b0;
                cmd_dev   = ~v.dev;
                cmd_data  = ~v.data;
            end
        end
        check({v.name, " rsp_data"}, 64'(rsp_data), 64'(v.rdata));
        check({v.name, " tty_pia"}, 64'(tty_pia), 64'(v.pia));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         k;
        int         pulses;
        logic [6:0] pats[4];
        logic [2:0] lvls[4];

        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_dev    = '0;
        cmd_data   = '0;
        bus_pi_req = '0;
        tty_pia    = 3'd0;

        vecs[0] = mk("cono_tty",  3'd0, TTY, 36'o3,   S_CC, 3, 4, S_CS, 6, 7, 8, 9, 1'b0, 36'o0,   3'd3);
        vecs[1] = mk("coni_tty",  3'd1, TTY, 36'o777, S_FS, 3, 5, 7'd0, 0, -1, 6, 7, 1'b0, 36'o3,  3'd3);
        vecs[2] = mk("datai_tty", 3'd3, TTY, 36'o0,   S_FD, 3, 5, 7'd0, 0, -1, 6, 7, 1'b0, 36'o101, 3'd3);
        vecs[3] = mk("datao_ptp", 3'd2, PTP, 36'o215, S_DC, 3, 4, S_DS, 6, 7, 8, 9, 1'b0, 36'o101, 3'd3);
        vecs[4] = mk("iorst",     3'd4, TTY, 36'o5,   S_RST, 1, 4, 7'd0, 0, -1, 0, 5, 1'b0, 36'o101, 3'd0);
        vecs[5] = mk("coni_rst",  3'd1, TTY, 36'o0,   S_FS, 3, 5, 7'd0, 0, -1, 6, 7, 1'b0, 36'o0,  3'd0);
        vecs[6] = mk("illegal",   3'd6, TTY, 36'o7,   7'd0, 0, -1, 7'd0, 0, -1, 0, 1, 1'b1, 36'o0, 3'd0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset strobes", 64'(strb), 64'd0);
        check("reset bus", 64'({ios, iob_out}), 64'd0);
        check("reset rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'd0);
        check("reset poweron", 64'(iob_poweron), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("poweron after reset", 64'(iob_poweron), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back DATAO with cmd_valid held: second accepted in cycle 10.
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'd2;
                cmd_dev   = PTP;
                cmd_data  = 36'o215;
            end
            k = c % 10;
            check($sformatf("b2b strobes c%0d", c), 64'(strb),
                  64'(((k >= 3 && k <= 4) ? S_DC : 7'd0) | ((k >= 6 && k <= 7) ? S_DS : 7'd0)));
            check($sformatf("b2b ready/rsp c%0d", c), 64'({cmd_ready, rsp_valid}),
                  64'({k == 0, k == 9}));
            check($sformatf("b2b ios c%0d", c), 64'(ios), 64'((k >= 1 && k <= 8) ? PTP : 7'd0));
            if (c == 11) cmd_valid = 1'b0;
        end

        // Reset asserted in cycle 4 of a CONO aborts it without a response.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_dev   = TTY;
        cmd_data  = 36'o5;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) cmd_valid = 1'b0;
        end
        check("abort cono_clear c4", 64'(cono_clear), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort strobes c5", 64'(strb), 64'd0);
        check("abort bus c5", 64'({ios, iob_out}), 64'd0);
        check("abort rsp c5", 64'({rsp_valid, rsp_err, rsp_data}), 64'd0);
        check("abort poweron c5", 64'(iob_poweron), 64'd0);
        reset  = 1'b1;
        pulses = 0;
        for (int c = 6; c <= 14; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        check("abort no rsp_valid", 64'(pulses), 64'd0);
        check("abort idle ready", 64'({cmd_ready, iob_poweron}), 64'd3);

        // PI request pass-through.
        pats[0] = 7'b0010100; lvls[0] = 3'd3;
        pats[1] = 7'b1000001; lvls[1] = 3'd1;
        pats[2] = 7'b0000001; lvls[2] = 3'd7;
        pats[3] = 7'b0000000; lvls[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus_pi_req = pats[i];
`ifdef IOB_PISYNC_EN
            @(posedge clk); #1;
            check($sformatf("pi_req lag %0d", i), 64'(pi_req), 64'(i == 0 ? 7'd0 : pats[i-1]));
            @(posedge clk); #1;
            check($sformatf("pi_req %0d", i), 64'(pi_req), 64'(pats[i]));
            check($sformatf("pi_lvl %0d", i), 64'(pi_lvl), 64'(lvls[i]));
`else
            #1;
            check($sformatf("pi_req %0d", i), 64'(pi_req), 64'(pats[i]));
            check($sformatf("pi_lvl_ref %0d", i), 64'(lvls[i] != 3'd0), 64'(pi_req != 7'd0));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
